data_stream_demultiplexer: RTL and testbench
============================================

DATA_STREAM_DEMULTIPLEXER -- requirements
Module: data_stream_demultiplexer

Interface
REQ-001 SHALL have parameter symbol_clk_f, default 1_000_000: symbol rate in Hz.
REQ-002 SHALL have parameter clk_f, default 100_000_000: clk frequency in Hz; C = clk_f/symbol_clk_f cycles per symbol period (default 100).
REQ-003 SHALL have parameter ds_width, default 8: width of each data stream.
REQ-004 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port symbol_clk  input  1  symbol strobe, synchronous to clk; its rising edge marks the period start.
REQ-007 SHALL have port mode  input  2  0 = off, 1 = one stream, 2 = two streams, 3 = three streams.
REQ-008 SHALL have port multiplexed_data  input  ds_width  time-division-multiplexed stream.
REQ-009 SHALL have ports ds1, ds2, ds3  output  ds_width each  recovered streams, registered.
REQ-010 SHALL have port ds_valid  output  1  one-cycle pulse when ds1..ds3 update.
REQ-011 SHALL have port sync_err  output  1  one-cycle pulse on a symbol edge that arrives out of place.

Function
REQ-012 SHALL detect a symbol edge when symbol_clk==1 and the registered previous symbol_clk==0; symbol_clk high at reset release counts as an edge.
REQ-013 SHALL keep slot counter cnt, width $clog2(C), in the range 0..C-1.
- On a detected edge: cnt <= 0.
- Otherwise: cnt increments; it wraps from C-1 to 0 (free-runs if an edge is missed).
REQ-014 SHALL implement FSM IDLE -> RUN on the first detected edge; RUN persists until reset.
- In IDLE: cnt holds 0, no sampling, no ds_valid.
REQ-015 SHALL latch mode into active_mode at each detected edge; a mode change mid-period takes effect only from the next period.
REQ-016 SHALL define slot bounds L2 = C/2, L3 = C/3, D3 = 2C/3, all integer division.
REQ-017 SHALL capture multiplexed_data into holding registers at slot midpoints; the value is the one present during the cycle with that cnt.
- mode 1: ds1 at C/2.
- mode 2: ds1 at L2/2; ds2 at L2 + L2/2.
- mode 3: ds1 at L3/2; ds2 at L3 + (D3-L3)/2; ds3 at D3 + (C-D3)/2.
- Defaults (C = 100): mode 1 samples at 50; mode 2 at 25, 75; mode 3 at 16, 49, 83.
REQ-018 SHALL force holding registers of streams unused by active_mode to 0.
REQ-019 SHALL, on the clock edge where cnt==C-1 in RUN, load ds1..ds3 from the holding registers and set ds_valid=1 for exactly one cycle.
- Latency from last sample to output is at most C cycles.
- Outputs hold their value between updates.
REQ-020 SHALL treat active_mode 0 as off: holding registers cleared; at cnt==C-1, ds1..ds3 are loaded with 0 and ds_valid stays 0.
REQ-021 SHALL handle an edge arriving in RUN while cnt != C-1 (early or late edge) as follows:
- pulse sync_err;
- discard the partial period, so no ds_valid for it;
- restart at cnt 0.
REQ-022 SHALL give priority to the edge when an edge and cnt==C-1 coincide: the period completes normally (ds_valid pulses, no sync_err) and cnt restarts at 0.
REQ-023 SHALL issue the first ds_valid only after one complete period following the IDLE->RUN transition.

Reset
REQ-024 SHALL, while rst==0, asynchronously force the following:
- state = IDLE, cnt = 0, active_mode = 0;
- previous symbol_clk = 0;
- holding registers = 0, ds1..ds3 = 0;
- ds_valid = 0, sync_err = 0.
REQ-025 SHALL, when reset is asserted mid-period, abandon that period; after release, the block waits in IDLE for a fresh edge.

Structure
REQ-026 SHALL take the mode encoding (typedef enum, 2 bits) and sample-point/slot-bound constant functions from shared package data_stream_pkg, which is also used by the multiplexer.
REQ-027 SHALL instantiate one sub-module, data_stream_slot_timer, containing edge detect, cnt, FSM and sync_err; the top level holds sampling and output registers.

Verification (defaults, C = 100)
REQ-028 SHALL verify mode 2: edge, then data 0xA1 in cycles 0-49 and 0xB2 in cycles 50-99 -> at cnt==99, ds1=0xA1, ds2=0xB2, ds3=0x00, ds_valid high 1 cycle.
REQ-029 SHALL verify mode 3: data 0x11 in cycles 0-32, 0x22 in 33-65, 0x33 in 66-99 -> ds1=0x11, ds2=0x22, ds3=0x33, one ds_valid per period over 4 periods.
REQ-030 SHALL verify an early edge: edge at cnt==60 in mode 1 -> sync_err 1 cycle, no ds_valid for that period, next period valid with cnt restarted.
REQ-031 SHALL verify mode change: mode 1 -> 3 changed at cnt==40 -> current period still decoded as mode 1; mode 3 output after the following period.
REQ-032 SHALL verify reset: rst low at cnt==70 -> all outputs 0 immediately; no ds_valid until one full period after the next edge.
REQ-033 SHALL verify mode 0: any data -> ds1..ds3 = 0 and ds_valid never asserted.

Source files
------------

// File: rtl/data_stream_pkg.sv
// Shared definitions for the TDM data-stream multiplexer/demultiplexer pair.
// Provides:
//   ds_mode_e     - stream-count encoding (off / one / two / three streams)
//   slot_state_e  - slot timer FSM states
//   cnt_width     - slot counter width for a given period length in cycles
//   slot_l2/l3/d3 - slot boundaries within one symbol period
//   sample_point  - cycle index at which stream idx is sampled for a mode
package data_stream_pkg;

    typedef enum logic [1:0] {
        ModeOff   = 2'd0,
        ModeOne   = 2'd1,
        ModeTwo   = 2'd2,
        ModeThree = 2'd3
    } ds_mode_e;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } slot_state_e;

    function automatic int unsigned cnt_width(input int unsigned c);
        return (c > 1) ? $clog2(c) : 1;
    endfunction

    function automatic int unsigned slot_l2(input int unsigned c);
        return c / 2;
    endfunction

    function automatic int unsigned slot_l3(input int unsigned c);
        return c / 3;
    endfunction

    function automatic int unsigned slot_d3(input int unsigned c);
        return (2 * c) / 3;
    endfunction

    // Midpoint of the slot that carries stream idx (0-based) in mode m.
    function automatic int unsigned sample_point(input int unsigned c, input ds_mode_e m,
                                                 input int unsigned idx);
        int unsigned pt;
        pt = 0;
        if (m == ModeOne) begin
            pt = c / 2;
        end else if (m == ModeTwo) begin
            pt = (idx == 0) ? slot_l2(c) / 2 : slot_l2(c) + slot_l2(c) / 2;
        end else if (m == ModeThree) begin
            if (idx == 0) begin
                pt = slot_l3(c) / 2;
            end else if (idx == 1) begin
                pt = slot_l3(c) + (slot_d3(c) - slot_l3(c)) / 2;
            end else begin
                pt = slot_d3(c) + (c - slot_d3(c)) / 2;
            end
        end
        return pt;
    endfunction

endpackage

// File: rtl/data_stream_slot_timer.sv
// Symbol-period slot timer: symbol edge detect, slot counter, IDLE/RUN FSM and
// out-of-place edge reporting.
// Ports:
//   clk_i, rst_ni    - clock, asynchronous active-low reset
//   symbol_clk_i     - symbol strobe, rising edge marks a period start
//   sym_edge_o       - combinational: symbol edge detected this cycle
//   cnt_o            - current slot counter value (0..Cycles-1)
//   period_end_o     - combinational: RUN and cnt at Cycles-1
//   sync_err_o       - registered one-cycle pulse for an edge with cnt != Cycles-1
module data_stream_slot_timer
    import data_stream_pkg::*;
#(
    parameter int unsigned Cycles = 100,
    parameter int unsigned CntW   = cnt_width(Cycles)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            symbol_clk_i,
    output logic            sym_edge_o,
    output logic [CntW-1:0] cnt_o,
    output logic            period_end_o,
    output logic            sync_err_o
);

    localparam logic [CntW-1:0] CntLast = CntW'(Cycles - 1);

    slot_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sym_prev_q;
    logic            sync_err_q, sync_err_d;
    logic            sym_edge, last_slot;

    // Previous strobe resets to 0 so a strobe held high through reset release is an edge.
    assign sym_edge  = symbol_clk_i & ~sym_prev_q;
    assign last_slot = (cnt_q == CntLast);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            sym_prev_q <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sym_prev_q <= symbol_clk_i;
            sync_err_q <= sync_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (sym_edge) state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d      = '0;
        sync_err_d = 1'b0;
        if (state_q == StRun) begin
            if (sym_edge) begin
                // An edge on the last slot is the expected one; anywhere else is out of place.
                sync_err_d = ~last_slot;
            end else if (!last_slot) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign sym_edge_o   = sym_edge;
    assign cnt_o        = cnt_q;
    assign period_end_o = (state_q == StRun) && last_slot;
    assign sync_err_o   = sync_err_q;

endmodule

// File: rtl/data_stream_demultiplexer.sv
// Time-division demultiplexer: recovers up to three streams from one TDM stream
// by sampling the midpoint of each slot and publishing once per symbol period.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   symbol_clk          - symbol strobe, synchronous to clk
//   mode                - 0 off, 1..3 number of streams (latched per period)
//   multiplexed_data    - TDM input stream
//   ds1, ds2, ds3       - recovered streams, registered
//   ds_valid            - one-cycle pulse when ds1..ds3 update
//   sync_err            - one-cycle pulse on an out-of-place symbol edge
module data_stream_demultiplexer
    import data_stream_pkg::*;
#(
    parameter int unsigned symbol_clk_f = 1_000_000,
    parameter int unsigned clk_f        = 100_000_000,
    parameter int unsigned ds_width     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                symbol_clk,
    input  logic [1:0]          mode,
    input  logic [ds_width-1:0] multiplexed_data,
    output logic [ds_width-1:0] ds1,
    output logic [ds_width-1:0] ds2,
    output logic [ds_width-1:0] ds3,
    output logic                ds_valid,
    output logic                sync_err
);

    localparam int unsigned C    = clk_f / symbol_clk_f;
    localparam int unsigned CntW = cnt_width(C);

    localparam logic [CntW-1:0] M1S0 = CntW'(sample_point(C, ModeOne, 0));
    localparam logic [CntW-1:0] M2S0 = CntW'(sample_point(C, ModeTwo, 0));
    localparam logic [CntW-1:0] M2S1 = CntW'(sample_point(C, ModeTwo, 1));
    localparam logic [CntW-1:0] M3S0 = CntW'(sample_point(C, ModeThree, 0));
    localparam logic [CntW-1:0] M3S1 = CntW'(sample_point(C, ModeThree, 1));
    localparam logic [CntW-1:0] M3S2 = CntW'(sample_point(C, ModeThree, 2));

    logic            sym_edge, period_end;
    logic [CntW-1:0] cnt;

    ds_mode_e                   active_mode_q, active_mode_d;
    logic [2:0][ds_width-1:0]   hold_q, hold_d;
    logic [2:0][ds_width-1:0]   ds_q, ds_d;
    logic                       ds_valid_q, ds_valid_d;

    data_stream_slot_timer #(
        .Cycles (C),
        .CntW   (CntW)
    ) u_slot_timer (
        .clk_i        (clk),
        .rst_ni       (rst),
        .symbol_clk_i (symbol_clk),
        .sym_edge_o   (sym_edge),
        .cnt_o        (cnt),
        .period_end_o (period_end),
        .sync_err_o   (sync_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_mode_q <= ModeOff;
            hold_q        <= '0;
            ds_q          <= '0;
            ds_valid_q    <= 1'b0;
        end else begin
            active_mode_q <= active_mode_d;
            hold_q        <= hold_d;
            ds_q          <= ds_d;
            ds_valid_q    <= ds_valid_d;
        end
    end

    // Mode is only picked up at a period boundary so a period is decoded consistently.
    assign active_mode_d = sym_edge ? ds_mode_e'(mode) : active_mode_q;

    // active_mode is Off whenever the timer is idle, so no extra run gating is needed.
    always_comb begin
        hold_d = hold_q;
        unique case (active_mode_q)
            ModeOff: begin
                hold_d = '0;
            end
            ModeOne: begin
                if (cnt == M1S0) hold_d[0] = multiplexed_data;
                hold_d[1] = '0;
                hold_d[2] = '0;
            end
            ModeTwo: begin
                if (cnt == M2S0) hold_d[0] = multiplexed_data;
                if (cnt == M2S1) hold_d[1] = multiplexed_data;
                hold_d[2] = '0;
            end
            ModeThree: begin
                if (cnt == M3S0) hold_d[0] = multiplexed_data;
                if (cnt == M3S1) hold_d[1] = multiplexed_data;
                if (cnt == M3S2) hold_d[2] = multiplexed_data;
            end
            default: hold_d = '0;
        endcase
    end

    // Publish from hold_d so a sample point on the last slot is still included.
    always_comb begin
        ds_d       = ds_q;
        ds_valid_d = 1'b0;
        if (period_end) begin
            ds_d       = hold_d;
            ds_valid_d = (active_mode_q != ModeOff);
        end
    end

    assign ds1      = ds_q[0];
    assign ds2      = ds_q[1];
    assign ds3      = ds_q[2];
    assign ds_valid = ds_valid_q;

endmodule

// File: tb/tb_data_stream_demultiplexer.sv
// Directed bench for data_stream_demultiplexer at default parameters (C = 100).
module tb_data_stream_demultiplexer;

    localparam int C = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       symbol_clk;
    logic [1:0] mode;
    logic [7:0] multiplexed_data;
    logic [7:0] ds1, ds2, ds3;
    logic       ds_valid, sync_err;

    int n_vec = 0;
    int n_err = 0;

    data_stream_demultiplexer dut (
        .clk              (clk),
        .rst              (rst),
        .symbol_clk       (symbol_clk),
        .mode             (mode),
        .multiplexed_data (multiplexed_data),
        .ds1              (ds1),
        .ds2              (ds2),
        .ds3              (ds3),
        .ds_valid         (ds_valid),
        .sync_err         (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one period starting at cnt 0; the symbol edge is placed in slot edge_k.
    task automatic run_period(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input int b1, input int b2,
                              input logic [1:0] new_mode, input int mc, input int edge_k,
                              input logic [23:0] exp_ds, input int exp_valid);
        int nv, ne, vk;
        nv = 0;
        ne = 0;
        vk = -1;
        for (int k = 0; k <= edge_k; k++) begin
            multiplexed_data = (k < b1) ? d0 : ((k < b2) ? d1 : d2);
            if (k == mc) mode = new_mode;
            symbol_clk = (k == edge_k);
            tick();
            if (ds_valid) begin
                nv++;
                vk = k;
            end
            if (sync_err) ne++;
        end
        symbol_clk = 1'b0;
        check_eq({tag, "_valid_cnt"}, 64'(nv), 64'(exp_valid));
        check_eq({tag, "_err_cnt"}, 64'(ne), (edge_k == C - 1) ? 64'd0 : 64'd1);
        check_eq({tag, "_ds"}, {40'd0, ds1, ds2, ds3}, {40'd0, exp_ds});
        if (exp_valid != 0) check_eq({tag, "_valid_slot"}, 64'(vk), 64'(C - 1));
    endtask

    initial begin
        int nv, ne;
        rst              = 1'b0;
        symbol_clk       = 1'b0;
        mode             = 2'd0;
        multiplexed_data = 8'h00;
        tick();
        tick();
        check_eq("reset_outputs", {38'd0, ds1, ds2, ds3, ds_valid, sync_err}, 64'd0);
        rst = 1'b1;

        // Idle: no strobe, nothing must come out.
        nv = 0;
        ne = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            nv += int'(ds_valid);
            ne += int'(sync_err);
        end
        check_eq("idle_valid", 64'(nv), 64'd0);
        check_eq("idle_err", 64'(ne), 64'd0);

        // First edge, mode 2.
        mode       = 2'd2;
        symbol_clk = 1'b1;
        tick();
        symbol_clk = 1'b0;
        check_eq("first_edge_err", {63'd0, sync_err}, 64'd0);

        run_period("mode2", 8'hA1, 8'hB2, 8'hB2, 50, 100, 2'd3, 0, C - 1, 24'hA1B200, 1);
        for (int p = 0; p < 4; p++) begin
            run_period($sformatf("mode3_p%0d", p), 8'h11, 8'h22, 8'h33, 33, 66,
                       (p == 3) ? 2'd1 : 2'd3, 0, C - 1, 24'h112233, 1);
        end
        run_period("mode1", 8'h10, 8'h5C, 8'h5C, 50, 100, 2'd1, 0, C - 1, 24'h5C0000, 1);

        // Early edge at cnt 60: partial period discarded, outputs keep the old value.
        run_period("early_edge", 8'h10, 8'h99, 8'h99, 50, 100, 2'd1, 0, 60, 24'h5C0000, 0);
        run_period("after_early", 8'h10, 8'h77, 8'h77, 50, 100, 2'd1, 0, C - 1, 24'h770000, 1);

        // Mode 1 -> 3 at cnt 40: this period still mode 1, the next one mode 3.
        run_period("mchg_cur", 8'h11, 8'h22, 8'h33, 33, 66, 2'd3, 40, C - 1, 24'h220000, 1);
        run_period("mchg_next", 8'h11, 8'h22, 8'h33, 33, 66, 2'd2, 0, C - 1, 24'h112233, 1);
        run_period("mode2_ds3_zero", 8'hA1, 8'hB2, 8'hB2, 50, 100, 2'd1, 0, C - 1,
                   24'hA1B200, 1);

        // Reset in the middle of a mode-1 period at cnt 70.
        for (int k = 0; k < 70; k++) begin
            multiplexed_data = 8'h44;
            tick();
        end
        rst = 1'b0;
        #1;
        check_eq("rst_async_outputs", {38'd0, ds1, ds2, ds3, ds_valid, sync_err}, 64'd0);
        tick();
        tick();
        rst = 1'b1;
        nv  = 0;
        ne  = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            nv += int'(ds_valid);
            ne += int'(sync_err);
        end
        check_eq("post_rst_idle_valid", 64'(nv), 64'd0);
        check_eq("post_rst_idle_err", 64'(ne), 64'd0);
        symbol_clk = 1'b1;
        tick();
        symbol_clk = 1'b0;
        check_eq("post_rst_edge_err", {63'd0, sync_err}, 64'd0);
        run_period("post_rst_mode1", 8'h44, 8'h44, 8'h44, 50, 100, 2'd0, 0, C - 1,
                   24'h440000, 1);

        // Mode 0: outputs cleared at period end, never valid.
        run_period("mode0", 8'hFF, 8'hFF, 8'hFF, 33, 66, 2'd0, 0, C - 1, 24'h000000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
